signal_debouncer: RTL

SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

---
 rtl/signal_debouncer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/signal_debouncer.sv
// Purpose : synchronise a raw asynchronous level and qualify every change over a programmable number of stable cycles.
// Latency : a clean step on RAW_IN appears on CLEAN_OUT SYNC_STAGES + thr_eff clock edges after RAW_IN changes.
// Backpr. : none; a free-running sampler with no handshake, so a disagreement that ends early is dropped and counted as a glitch.
//
// Ports
//   CLK             sole clock, rising edge
//   RSTN            synchronous active-low reset
//   RAW_IN          asynchronous raw level; only the synchroniser sees it
//   ENABLE          low freezes CLEAN_OUT and abandons any qualification
//   DEBOUNCE_CYCLES stability threshold in CLK cycles (0 behaves as 1)
//   GLITCH_CLR      single-cycle clear of GLITCH_CNT_OUT; wins over an increment
//   CLEAN_OUT       registered debounced level
//   BUSY_OUT        high while a candidate transition is being qualified
//   GLITCH_CNT_OUT  saturating count of rejected transitions
module signal_debouncer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 RAW_IN,
    input  logic                 ENABLE,
    input  logic [CNT_WIDTH-1:0] DEBOUNCE_CYCLES,
    input  logic                 GLITCH_CLR,
    output logic                 CLEAN_OUT,
    output logic                 BUSY_OUT,
    output logic [7:0]           GLITCH_CNT_OUT
);

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_QUALIFY = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [7:0]           GLITCH_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // Synchroniser: RAW_IN enters at bit 0, sync_q is the last stage.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], RAW_IN};
        end
    end

    assign sync_q = sync_chain[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Qualification FSM
    // ------------------------------------------------------------------
    logic [0:0]           state_q,  state_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0] thr_q,    thr_d;
    logic                 clean_q,  clean_d;
    logic [7:0]           glitch_q, glitch_d;

    logic [CNT_WIDTH-1:0] thr_eff;
    logic                 thr_is_one;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 differs;
    logic                 glitch_evt;

    // A programmed 0 behaves exactly like 1: the change is taken immediately.
    assign thr_eff    = (DEBOUNCE_CYCLES == CNT_ZERO) ? CNT_ONE : DEBOUNCE_CYCLES;
    assign thr_is_one = (thr_eff == CNT_ONE);

    // The counter only ever holds values below the latched threshold, so the
    // increment reaches at most the threshold itself and cannot wrap, even
    // with an all-ones threshold.
    assign cnt_inc = cnt_q + CNT_ONE;
    assign differs = (sync_q != clean_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        thr_d      = thr_q;
        clean_d    = clean_q;
        glitch_evt = 1'b0;

        if (!ENABLE) begin
            // Abandon silently: an interrupted qualification is not a glitch.
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    cnt_d = CNT_ZERO;
                    if (differs) begin
                        if (thr_is_one) begin
                            clean_d = sync_q;
                        end else begin
                            // Threshold is captured here so later writes to
                            // DEBOUNCE_CYCLES cannot disturb this attempt.
                            cnt_d   = CNT_ONE;
                            thr_d   = thr_eff;
                            state_d = ST_QUALIFY;
                        end
                    end
                end

                ST_QUALIFY: begin
                    if (differs) begin
                        if (cnt_inc == thr_q) begin
                            clean_d = sync_q;
                            cnt_d   = CNT_ZERO;
                            state_d = ST_STABLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Input fell back before the threshold was reached.
                        cnt_d      = CNT_ZERO;
                        state_d    = ST_STABLE;
                        glitch_evt = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Clear has priority over a simultaneous rejected transition.
    always_comb begin
        glitch_d = glitch_q;
        if (GLITCH_CLR) begin
            glitch_d = 8'h00;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= ST_STABLE;
            cnt_q    <= CNT_ZERO;
            thr_q    <= CNT_ZERO;
            clean_q  <= 1'b0;
            glitch_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            clean_q  <= clean_d;
            glitch_q <= glitch_d;
        end
    end

    assign CLEAN_OUT      = clean_q;
    assign BUSY_OUT       = (state_q == ST_QUALIFY);
    assign GLITCH_CNT_OUT = glitch_q;

endmodule
